// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   - opcode constants for control-flow instructions
//   - canonical NOP encoding (addi x0, x0, 0)
//   - fetch FSM state encoding
//   - small helpers used by the fetch logic
package riscv_pkg;

    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // Sequential fetch address; the 32-bit add wraps 0xFFFF_FFFC to 0.
    function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // True for opcodes that can redirect the fetch stream.
    function automatic logic is_ctrl_flow(input logic [6:0] opcode);
        return (opcode == OPCODE_BRANCH) || (opcode == OPCODE_JAL) ||
               (opcode == OPCODE_JALR);
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry instruction output register between fetch and decode.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   fill            load fill_inst/fill_pc this cycle
//   flush           drop the entry (redirect); wins over fill and ready
//   ready           decode consumes the entry this cycle
//   fill_inst/pc    incoming instruction word and its address
//   valid/inst/pc   registered entry presented to decode
module fetch_out_buf
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic              flush,
    input  logic              ready,
    input  logic [DATA_W-1:0] fill_inst,
    input  logic [DATA_W-1:0] fill_pc,
    output logic              valid,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            inst  <= DATA_W'(NOP_INST);
            pc    <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (fill) begin
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
            // Data only moves on a real load, so a stalled entry stays put.
            if (fill && !flush) begin
                inst <= fill_inst;
                pc   <= fill_pc;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, redirect handling and a four-state
// request FSM with at most one outstanding instruction-memory request.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   BranchTaken, JumpTaken         redirect requests from execute
//   TargetPC                       redirect address (low two bits ignored)
//   IMemReqValid/Addr/Ready        instruction memory request handshake
//   IMemRespValid/Data             instruction memory response
//   InstValid, Inst, InstPC        instruction presented to decode
//   InstReady                      decode accepts the instruction
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        BranchTaken,
    input  logic        JumpTaken,
    input  logic [31:0] TargetPC,
    output logic        IMemReqValid,
    output logic [31:0] IMemReqAddr,
    input  logic        IMemReqReady,
    input  logic        IMemRespValid,
    input  logic [31:0] IMemRespData,
    output logic        InstValid,
    output logic [31:0] Inst,
    output logic [31:0] InstPC,
    input  logic        InstReady
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         buf_free;
    logic         req_valid;
    logic         fill;

    assign redirect    = BranchTaken | JumpTaken;
    assign redirect_pc = TargetPC & 32'hFFFF_FFFC;
    // A new request may only go out if its result will have somewhere to land.
    assign buf_free    = !InstValid || InstReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_valid = 1'b0;
        fill      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) pc_d = redirect_pc;
            end
            REQ: begin
                req_valid = buf_free;
                if (redirect) pc_d = redirect_pc;
                // A redirect racing the handshake leaves a stale request in
                // flight; DROP swallows its response.
                if (req_valid && IMemReqReady) state_d = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (IMemRespValid) begin
                    state_d = REQ;
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else begin
                        fill = 1'b1;
                        pc_d = next_fetch_pc(pc_q);
                    end
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (redirect) pc_d = redirect_pc;
                if (IMemRespValid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    assign IMemReqValid = req_valid;
    assign IMemReqAddr  = pc_q;

    fetch_out_buf #(
        .DATA_W(32)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .fill     (fill),
        .flush    (redirect),
        .ready    (InstReady),
        .fill_inst(IMemRespData),
        .fill_pc  (pc_q),
        .valid    (InstValid),
        .inst     (Inst),
        .pc       (InstPC)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run with a variable-latency memory and random redirects.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        BranchTaken, JumpTaken;
    logic [31:0] TargetPC;
    logic        IMemReqValid;
    logic [31:0] IMemReqAddr;
    logic        IMemReqReady;
    logic        IMemRespValid;
    logic [31:0] IMemRespData;
    logic        InstValid;
    logic [31:0] Inst, InstPC;
    logic        InstReady;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .BranchTaken  (BranchTaken),
        .JumpTaken    (JumpTaken),
        .TargetPC     (TargetPC),
        .IMemReqValid (IMemReqValid),
        .IMemReqAddr  (IMemReqAddr),
        .IMemReqReady (IMemReqReady),
        .IMemRespValid(IMemRespValid),
        .IMemRespData (IMemRespData),
        .InstValid    (InstValid),
        .Inst         (Inst),
        .InstPC       (InstPC),
        .InstReady    (InstReady)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- memory model / driver ----------------
    bit          pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] paddr = 32'h0;
    int          lat_fix = 1;

    task automatic drive(input bit rdy, input bit irdy, input bit br, input bit jp,
                         input logic [31:0] tgt, input bit inject, input bit jp_on_resp);
        bit resp;
        int l;
        @(posedge clk);
        #1;
        resp = 1'b0;
        if (inject) begin
            resp = 1'b1;
            IMemRespData = 32'hDEAD_BEEF;
            pend = 1'b0;
        end else if (pend && cnt <= 1) begin
            resp = 1'b1;
            IMemRespData = mem_word(paddr);
        end else begin
            if (pend) cnt--;
            IMemRespData = $urandom;
        end
        IMemRespValid = resp;
        IMemReqReady  = rdy;
        InstReady     = irdy;
        BranchTaken   = br;
        JumpTaken     = jp | (jp_on_resp & resp);
        TargetPC      = tgt;
        @(negedge clk);
        if (IMemRespValid) pend = 1'b0;
        if (IMemReqValid && IMemReqReady) begin
            l     = (lat_fix == 0) ? int'($urandom_range(1, 3)) : lat_fix;
            pend  = 1'b1;
            cnt   = l;
            paddr = IMemReqAddr;
        end
    endtask

    function automatic bit hs_now();
        return IMemReqValid && IMemReqReady && !BranchTaken && !JumpTaken;
    endfunction

    task automatic wait_hs(input bit now_ok, input string name, output logic [31:0] a);
        int n = 0;
        bit hit;
        hit = now_ok && hs_now();
        while (!hit && n < 50) begin
            drive(1, 1, 0, 0, 32'h0, 0, 0);
            n++;
            hit = hs_now();
        end
        chk({name, "_timeout"}, {31'b0, hit}, 32'd1);
        a = IMemReqAddr;
    endtask

    task automatic wait_item(input string name);
        int n = 0;
        do begin
            drive(1, 1, 0, 0, 32'h0, 0, 0);
            n++;
        end while (!InstValid && n < 50);
        chk({name, "_timeout"}, {31'b0, InstValid}, 32'd1);
    endtask

    // ---------------- behavioural reference / compare ----------------
    // The model only knows the architectural rules: every delivered
    // instruction is mem[PC] with PC following the sequential stream,
    // restarted at the aligned target by each redirect.
    logic [31:0] exp_pc = RESET_PC;
    bit          prev_valid = 0, prev_ready = 0, prev_redir = 0;
    logic [31:0] prev_inst = 32'h0, prev_pc = 32'h0;
    bit          outstanding = 0;
    int          idle_cnt = 0;

    always @(negedge clk) begin
        bit redir;
        if (!rst_n) begin
            chk("rst_reqvalid", {31'b0, IMemReqValid}, 32'd0);
            chk("rst_reqaddr",  IMemReqAddr, RESET_PC);
            chk("rst_instvalid", {31'b0, InstValid}, 32'd0);
            chk("rst_inst",   Inst,   NOP);
            chk("rst_instpc", InstPC, 32'h0);
            exp_pc      = RESET_PC;
            prev_valid  = 0;
            prev_redir  = 0;
            outstanding = 0;
            idle_cnt    = 0;
        end else begin
            redir = BranchTaken || JumpTaken;
            if (prev_redir) chk("redirect_clears_valid", {31'b0, InstValid}, 32'd0);
            if (InstValid) begin
                if (!prev_valid || prev_ready) begin
                    chk("deliver_pc",   InstPC, exp_pc);
                    chk("deliver_inst", Inst,   mem_word(InstPC));
                    exp_pc   = InstPC + 32'd4;
                    idle_cnt = 0;
                end else begin
                    chk("hold_inst", Inst,   prev_inst);
                    chk("hold_pc",   InstPC, prev_pc);
                end
            end
            if (InstValid && !InstReady) chk("stall_no_req", {31'b0, IMemReqValid}, 32'd0);
            if (IMemRespValid) outstanding = 0;
            chk("one_outstanding", {31'b0, IMemReqValid && outstanding}, 32'd0);
            if (IMemReqValid) chk("req_aligned", IMemReqAddr & 32'h3, 32'h0);
            if (IMemReqValid && IMemReqReady) begin
                if (!redir) chk("req_addr", IMemReqAddr, exp_pc);
                outstanding = 1;
            end
            if (redir) begin
                exp_pc   = TargetPC & 32'hFFFF_FFFC;
                idle_cnt = 0;
            end
            idle_cnt++;
            if (idle_cnt > 300) begin
                chk("progress_watchdog", 32'd1, 32'd0);
                idle_cnt = 0;
            end
            prev_redir = redir;
            prev_valid = InstValid;
            prev_ready = InstReady;
            prev_inst  = Inst;
            prev_pc    = InstPC;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] first;
        bit          got;
        bit          jumped;
        int          n;
        logic [31:0] tgt;

        BranchTaken = 0; JumpTaken = 0; TargetPC = 0;
        IMemReqReady = 0; IMemRespValid = 0; IMemRespData = 0; InstReady = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) drive(1, 0, 0, 0, 32'h0, 0, 0);
        chk("reset_inst_lit", Inst, 32'h0000_0013);
        chk("reset_addr_lit", IMemReqAddr, 32'h0);
        #2 rst_n = 1'b1;

        // First fetch with zero-wait memory, decode stalled.
        lat_fix = 1;
        got = 0; first = 32'hFFFF_FFFF; n = 0;
        while (!InstValid && n < 20) begin
            drive(1, 0, 0, 0, 32'h0, 0, 0);
            if (!got && IMemReqValid && IMemReqReady) begin
                got = 1;
                first = IMemReqAddr;
            end
            n++;
        end
        chk("first_req_addr", first, 32'h0);
        chk("first_valid", {31'b0, InstValid}, 32'd1);
        chk("first_inst", Inst, 32'h0010_0093);
        chk("first_instpc", InstPC, 32'h0);

        // Decode holds off for five cycles.
        repeat (5) begin
            drive(1, 0, 0, 0, 32'h0, 0, 0);
            chk("stall_inst_lit", Inst, 32'h0010_0093);
            chk("stall_pc_lit", InstPC, 32'h0);
            chk("stall_reqvalid_lit", {31'b0, IMemReqValid}, 32'd0);
        end
        drive(1, 1, 0, 0, 32'h0, 0, 0);
        chk("resume_reqvalid", {31'b0, IMemReqValid}, 32'd1);
        chk("resume_addr", IMemReqAddr, 32'h4);
        repeat (6) drive(1, 1, 0, 0, 32'h0, 0, 0);

        // Branch while a slow request is outstanding.
        lat_fix = 3;
        wait_hs(0, "br_pre_hs", a);
        drive(1, 1, 1, 0, 32'h0000_0103, 0, 0);
        wait_hs(0, "br_hs", a);
        chk("br_next_addr", a, 32'h0000_0100);
        wait_item("br_item");
        chk("br_item_pc", InstPC, 32'h0000_0100);
        chk("br_item_inst", Inst, mem_word(32'h0000_0100));

        // Jump landing on the same cycle as a response.
        lat_fix = 1;
        jumped = 0; n = 0;
        while (!jumped && n < 50) begin
            drive(1, 1, 0, 0, 32'h0000_2000, 0, 1);
            jumped = IMemRespValid && JumpTaken;
            n++;
        end
        chk("jmp_seen", {31'b0, jumped}, 32'd1);
        drive(1, 1, 0, 0, 32'h0, 0, 0);
        chk("jmp_no_inst", {31'b0, InstValid}, 32'd0);
        wait_hs(1, "jmp_hs", a);
        chk("jmp_next_addr", a, 32'h0000_2000);
        wait_item("jmp_item");
        chk("jmp_item_pc", InstPC, 32'h0000_2000);

        // Redirect to the top of the address space, then wrap.
        drive(1, 1, 1, 0, 32'hFFFF_FFFF, 0, 0);
        wait_hs(1, "wrap_hs", a);
        chk("wrap_top_addr", a, 32'hFFFF_FFFC);
        wait_item("wrap_item");
        chk("wrap_item_pc", InstPC, 32'hFFFF_FFFC);
        wait_hs(1, "wrap_next_hs", a);
        chk("wrap_next_addr", a, 32'h0000_0000);

        // Reset in the middle of an outstanding request; stale response after release.
        lat_fix = 3;
        wait_hs(0, "rst_pre_hs", a);
        drive(1, 1, 0, 0, 32'h0, 0, 0);
        #2 rst_n = 1'b0;
        pend = 1'b0;
        #1;
        chk("midrst_reqvalid", {31'b0, IMemReqValid}, 32'd0);
        chk("midrst_addr", IMemReqAddr, RESET_PC);
        chk("midrst_valid", {31'b0, InstValid}, 32'd0);
        chk("midrst_inst", Inst, 32'h0000_0013);
        chk("midrst_instpc", InstPC, 32'h0);
        drive(1, 1, 0, 0, 32'h0, 0, 0);
        drive(1, 1, 0, 0, 32'h0, 1, 0);
        #2 rst_n = 1'b1;
        wait_item("rst_item");
        chk("rst_item_pc", InstPC, RESET_PC);
        chk("rst_item_inst", Inst, 32'h0010_0093);

        // Randomized traffic.
        lat_fix = 0;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       tgt = 32'($urandom_range(0, 255));
                default: tgt = $urandom;
            endcase
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3, tgt, 0, 0);
        end
        repeat (20) drive(1, 1, 0, 0, 32'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 BranchTaken  input  1  conditional branch resolved taken (from branch unit).
REQ-005 JumpTaken  input  1  JAL/JALR resolved.
REQ-006 TargetPC  input  32  redirect address, valid when BranchTaken or JumpTaken.
REQ-007 IMemReqValid  output  1  fetch request valid.
REQ-008 IMemReqAddr  output  32  fetch address (word-aligned).
REQ-009 IMemReqReady  input  1  memory accepts request this cycle.
REQ-010 IMemRespValid  input  1  instruction word returned.
REQ-011 IMemRespData  input  32  returned instruction word.
REQ-012 InstValid  output  1  Inst/InstPC valid to decode.
REQ-013 Inst  output  32  fetched instruction.
REQ-014 InstPC  output  32  address of Inst.
REQ-015 InstReady  input  1  decode consumes Inst this cycle.

Function
REQ-016 Redirect SHALL be defined as BranchTaken OR JumpTaken; TargetPC[1:0] SHALL be forced to 2'b00.
REQ-017 States SHALL be IDLE, REQ, WAIT, DROP; at most one request SHALL be outstanding.
REQ-018 IDLE: exit to REQ on the first clock after reset release; IMemReqValid low.
REQ-019 REQ: IMemReqValid high and IMemReqAddr = PC only while the output buffer is empty or is consumed this cycle; on IMemReqReady go to WAIT.
REQ-020 WAIT: on IMemRespValid load Inst = IMemRespData, InstPC = PC, set InstValid next cycle, PC <= PC+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), go to REQ.
REQ-021 Output buffer SHALL hold Inst/InstPC/InstValid stable while InstValid=1 and InstReady=0; cleared on InstReady unless refilled same cycle.
REQ-022 Redirect in IDLE or REQ without handshake: PC <= TargetPC; next request carries TargetPC on the following cycle.
REQ-023 Redirect coincident with REQ handshake, or in WAIT without IMemRespValid: PC <= TargetPC, go to DROP.
REQ-024 DROP: discard next response without loading buffer, then go to REQ; further redirects in DROP update PC only.
REQ-025 Redirect coincident with IMemRespValid in WAIT: response discarded, PC <= TargetPC, go to REQ.
REQ-026 Any redirect SHALL clear InstValid next cycle, overriding InstReady and any same-cycle refill.
REQ-027 Minimum latency: request accepted cycle N, response cycle N+1, InstValid cycle N+2; back-to-back throughput one instruction per two cycles minimum under zero-wait memory.

Reset
REQ-028 On rst_n low, immediately: state IDLE, PC = RESET_PC, IMemReqValid = 0, IMemReqAddr = RESET_PC, InstValid = 0, Inst = 32'h0000_0013 (NOP), InstPC = 32'h0.
REQ-029 Reset asserted mid-WAIT SHALL abandon the outstanding request; a response arriving after release in IDLE SHALL be ignored.

Structure
REQ-030 Shared package riscv_pkg SHALL hold OPCODE_BRANCH (7'b1100011), OPCODE_JAL, OPCODE_JALR, NOP_INST (32'h0000_0013) and the fetch state encoding.
REQ-031 One sub-module, fetch_out_buf (one-entry output register with valid/ready), SHALL implement REQ-021/026.
REQ-032 Redirect logic, PC register and FSM SHALL reside in fetch_unit top.

Verification
REQ-033 Reset release, zero-wait memory returning 32'h0010_0093 at 0 -> first IMemReqAddr 0x0, InstValid with Inst 32'h0010_0093, InstPC 0x0, next request 0x4.
REQ-034 InstReady held 0 for 5 cycles with InstValid=1 -> Inst/InstPC unchanged, IMemReqValid low until InstReady=1.
REQ-035 BranchTaken=1, TargetPC=0x0000_0103 during WAIT -> in-flight response dropped, next IMemReqAddr 0x0000_0100, no instruction from old PC delivered.
REQ-036 JumpTaken=1 coincident with IMemRespValid -> that response never appears on Inst; next request 0x TargetPC.
REQ-037 PC forced to 32'hFFFF_FFFC via redirect -> following request address 32'h0000_0000.
REQ-038 rst_n low during WAIT, response arrives after release -> outputs at reset values, first delivered InstPC = RESET_PC.
